// File: rtl/m_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: default sizing,
// reset fetch address, the NOP shown to decode, and the queue entry layout.
package m_fetch_queue_pkg;

  localparam int unsigned FETCH_DEPTH    = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Circular buffer of {pc, ir} entries with push/pop/clear. Push and pop may
// coincide at any occupancy; the caller guarantees no push into a full buffer.
module m_fetch_fifo
  import m_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic         w_clock,
  input  logic         w_rst_n,
  input  logic         w_push,
  input  fetch_entry_t w_push_data,
  input  logic         w_pop,
  input  logic         w_clear,
  output fetch_entry_t w_head,
  output logic [AW:0]  w_count,
  output logic         w_full,
  output logic         w_empty
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  fetch_entry_t  mem [DEPTH];

  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      w_count <= '0;
    end else if (w_clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      w_count <= '0;
    end else begin
      if (w_push) wr_ptr <= wr_ptr + AW'(1);
      if (w_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (w_push && !w_pop)      w_count <= w_count + (AW+1)'(1);
      else if (!w_push && w_pop) w_count <= w_count - (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge w_clock) begin
    if (w_push && !w_clear) mem[wr_ptr] <= w_push_data;
  end

  assign w_head  = mem[rd_ptr];
  assign w_full  = (w_count == (AW+1)'(DEPTH));
  assign w_empty = (w_count == '0);

endmodule

// File: rtl/m_fetch_queue.sv
// Instruction-fetch front end: issues in-order imem requests under a credit
// limit, queues returned {pc, ir} pairs and hands them to decode.
module m_fetch_queue
  import m_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] NOP      = FETCH_NOP
) (
  input  logic        w_clock,
  input  logic        w_rst_n,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic        w_imem_req,
  output logic [31:0] w_imem_addr,
  input  logic        w_imem_gnt,
  input  logic        w_imem_rvalid,
  input  logic [31:0] w_imem_rdata,
  output logic        w_out_valid,
  output logic [31:0] w_out_ir,
  output logic [31:0] w_out_pc,
  input  logic        w_out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(2 * DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] in_use;
  logic          accept;
  logic          live_rsp;
  logic          drop_rsp;
  logic          push;
  logic          pop;
  logic [AW:0]   q_count;
  logic          q_full;
  logic          q_empty;
  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;

  // Both interfaces use valid/ready: a transfer happens exactly in a cycle where
  // valid (w_imem_req / w_out_valid) and ready (w_imem_gnt / w_out_ready) are
  // both high; valid never depends on ready in the same cycle.
  assign in_use      = CW'(q_count) + outstanding;
  assign w_imem_req  = w_rst_n && !w_redirect && (in_use < CW'(DEPTH));
  assign w_imem_addr = fetch_pc;
  assign accept      = w_imem_req && w_imem_gnt;

  // Responses owed to a flushed path are consumed first, in order.
  assign live_rsp    = w_imem_rvalid && (drop == '0);
  assign drop_rsp    = w_imem_rvalid && (drop != '0);
  assign push        = live_rsp && !w_redirect;
  assign pop         = w_out_valid && w_out_ready;
  assign q_push_data = '{pc: resp_pc, ir: w_imem_rdata};

  always_ff @(posedge w_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (w_redirect) begin
      fetch_pc    <= word_align(w_redirect_pc);
      resp_pc     <= word_align(w_redirect_pc);
      outstanding <= '0;
      drop        <= drop + outstanding - CW'(w_imem_rvalid);
    end else begin
      if (accept)   fetch_pc <= fetch_pc + 32'd4;
      if (live_rsp) resp_pc  <= resp_pc + 32'd4;
      outstanding <= outstanding + CW'(accept) - CW'(live_rsp);
      if (drop_rsp) drop <= drop - CW'(1);
    end
  end

  m_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .w_clock     (w_clock),
    .w_rst_n     (w_rst_n),
    .w_push      (push),
    .w_push_data (q_push_data),
    .w_pop       (pop),
    .w_clear     (w_redirect),
    .w_head      (q_head),
    .w_count     (q_count),
    .w_full      (q_full),
    .w_empty     (q_empty)
  );

  assign w_out_valid = !q_empty;
  assign w_out_ir    = q_empty ? NOP : q_head.ir;
  assign w_out_pc    = q_empty ? 32'h0 : q_head.pc;

  a_rsp_owed : assert property (@(posedge w_clock) disable iff (!w_rst_n)
    w_imem_rvalid |-> (outstanding != '0 || drop != '0));

  a_no_overflow : assert property (@(posedge w_clock) disable iff (!w_rst_n)
    push |-> (!q_full || pop));

endmodule

// File: tb/tb_m_fetch_queue.sv
// Bench for m_fetch_queue: an in-order variable-latency imem model drives the
// DUT while a queue-level reference model predicts every output each cycle.
module tb_m_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_ir;
  logic [31:0] out_pc;
  logic        out_ready;

  m_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .w_clock       (clk),
    .w_rst_n       (rst_n),
    .w_redirect    (redirect),
    .w_redirect_pc (redirect_pc),
    .w_imem_req    (imem_req),
    .w_imem_addr   (imem_addr),
    .w_imem_gnt    (imem_gnt),
    .w_imem_rvalid (imem_rvalid),
    .w_imem_rdata  (imem_rdata),
    .w_out_valid   (out_valid),
    .w_out_ir      (out_ir),
    .w_out_pc      (out_pc),
    .w_out_ready   (out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];        // visible entries {pc, ir}, head first
  logic [31:0] live_q[$];       // PCs of current-path requests not yet answered
  int          drop_cnt;
  logic [31:0] exp_fetch_pc;

  logic [31:0] mem_data_q[$];
  int          mem_due_q[$];
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] salt = 32'h0;
  int          n_req = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    exp_q.delete();
    live_q.delete();
    mem_data_q.delete();
    mem_due_q.delete();
    drop_cnt     = 0;
    exp_fetch_pc = RESET_PC;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   64'(imem_req),  64'd0);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_ir"},    64'(out_ir),    64'(NOP));
    check_eq({tag, "_pc"},    64'(out_pc),    64'd0);
  endtask

  // Asserts reset asynchronously, checks outputs at once, releases mid-cycle.
  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    out_ready   = 1'b0;
    #1;
    check_reset_outputs("rst_now");
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive imem response, check outputs, advance both models.
  task automatic tick();
    logic        exp_valid;
    logic        exp_req;
    logic [31:0] p;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data_q[0];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
    exp_valid = (exp_q.size() > 0);
    check_eq("out_valid", 64'(out_valid), 64'(exp_valid));
    check_eq("out_pc", 64'(out_pc), exp_valid ? 64'(exp_q[0][63:32]) : 64'd0);
    check_eq("out_ir", 64'(out_ir), exp_valid ? 64'(exp_q[0][31:0]) : 64'(NOP));
    exp_req = (exp_q.size() + live_q.size() < DEPTH) && !redirect;
    check_eq("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check_eq("imem_addr", 64'(imem_addr), 64'(exp_fetch_pc));

    // imem behaviour: answer each accepted request in order
    if (imem_req && imem_gnt) begin
      n_req++;
      mem_data_q.push_back(imem_addr ^ salt);
      mem_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (imem_rvalid) begin
      void'(mem_data_q.pop_front());
      void'(mem_due_q.pop_front());
    end

    // reference model
    if (exp_valid && out_ready) void'(exp_q.pop_front());
    if (imem_rvalid) begin
      if (drop_cnt > 0) drop_cnt--;
      else if (live_q.size() == 0) check_eq("stray_rsp", 64'd1, 64'd0);
      else begin
        p = live_q.pop_front();
        if (!redirect) exp_q.push_back({p, imem_rdata});
      end
    end
    if (redirect) begin
      drop_cnt += live_q.size();
      live_q.delete();
      exp_q.delete();
      exp_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else if (exp_req && imem_gnt) begin
      live_q.push_back(exp_fetch_pc);
      exp_fetch_pc += 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first;
    int req_before;
    int found;
    redirect_pc = 32'h0;
    imem_rdata  = 32'h0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: streaming, latency 1, ir equals pc
    salt = 32'h0; lat_min = 1; lat_max = 1;
    imem_gnt = 1'b1; out_ready = 1'b1;
    first = -1;
    for (int i = 0; i < 14; i++) begin
      if (out_valid && first < 0) first = i;
      tick();
    end
    check_eq("t1_first_valid", 64'(first), 64'd2);

    // 2: decode stalled, credits stop requests at DEPTH
    salt = 32'h5a5a_0000;
    imem_gnt = 1'b0; out_ready = 1'b1;
    run(6);
    out_ready = 1'b0; imem_gnt = 1'b1;
    req_before = n_req;
    run(10);
    check_eq("t2_req_count", 64'(n_req - req_before), 64'(DEPTH));
    check_eq("t2_req_low", 64'(imem_req), 64'd0);

    // 3: drain while refilling, pushes and pops overlap
    out_ready = 1'b1;
    run(12);
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 3) != 0;
      tick();
    end

    // 4: three requests in flight at latency 5, then redirect
    out_ready = 1'b1; imem_gnt = 1'b0;
    run(10);
    lat_min = 5; lat_max = 5;
    imem_gnt = 1'b1;
    run(3);
    imem_gnt = 1'b0;
    run(1);
    redirect = 1'b1; redirect_pc = 32'h0000_0103; imem_gnt = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    check_eq("t4_new_addr", 64'(imem_addr), 64'h100);
    first = 0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      tick();
      first++;
    end
    check_eq("t4_first_pc", 64'(out_pc), 64'h100);
    run(6);

    // 5: redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    run(6);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc && exp_q.size() > 0) begin
        found = 1;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check_eq("t5_valid_after", 64'(out_valid), 64'd0);
      end else begin
        tick();
      end
    end
    check_eq("t5_setup", 64'(found), 64'd1);
    run(10);

    // 6: reset with two requests in flight
    imem_gnt = 1'b0;
    run(10);
    lat_min = 5; lat_max = 5; imem_gnt = 1'b1;
    run(2);
    #2;
    do_reset();
    #1;
    check_eq("t6_restart_req", 64'(imem_req), 64'd1);
    check_eq("t6_restart_addr", 64'(imem_addr), 64'(RESET_PC));
    lat_min = 1; lat_max = 1; imem_gnt = 1'b1; out_ready = 1'b1;
    run(10);

    // address wrap across 2^32
    redirect = 1'b1; redirect_pc = 32'hffff_fffa;
    tick();
    redirect = 1'b0;
    run(12);

    // randomized traffic with redirects stacking on pending drops
    salt = $urandom; lat_min = 1; lat_max = 6;
    for (int i = 0; i < 1500; i++) begin
      imem_gnt    = $urandom_range(3, 0) != 0;
      out_ready   = $urandom_range(3, 0) != 0;
      redirect    = $urandom_range(24, 0) == 0;
      redirect_pc = $urandom;
      tick();
    end
    redirect = 1'b0;
    imem_gnt = 1'b0; out_ready = 1'b1;
    run(20);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
